// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZCV flag register plus registered B.cond evaluation.
// Supports same-cycle flag forwarding, stall and flush.
`default_nettype none

module cond_flag_unit #(
  parameter bit FORWARD   = 1'b1,
  parameter bit NV_ALWAYS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       setFlags,
  input  logic       aluN,
  input  logic       aluZ,
  input  logic       aluC,
  input  logic       aluV,
  input  logic       condValid,
  input  logic [3:0] cond,
  output logic       flagN,
  output logic       flagZ,
  output logic       flagC,
  output logic       flagV,
  output logic       BCondCheck,
  output logic       bcValid
);

  logic       sf;
  logic       cv;
  logic       fwd_sel;
  logic [3:0] alu_flags;
  logic [3:0] stored_flags;
  logic [3:0] eval_flags;
  logic       n, z, c, v;
  logic       cond_true;

  assign sf           = setFlags & ~flush & ~stall;
  assign cv           = condValid & ~flush & ~stall;
  assign alu_flags    = {aluN, aluZ, aluC, aluV};
  assign stored_flags = {flagN, flagZ, flagC, flagV};

  // Forwarding ignores stall: a stalled B.cond is not accepted anyway.
  assign fwd_sel    = FORWARD & setFlags & ~flush;
  assign eval_flags = fwd_sel ? alu_flags : stored_flags;
  assign {n, z, c, v} = eval_flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = z | (n != v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = NV_ALWAYS;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {flagN, flagZ, flagC, flagV} <= 4'b0000;
      BCondCheck                   <= 1'b0;
      bcValid                      <= 1'b0;
    end else begin
      if (sf) begin
        {flagN, flagZ, flagC, flagV} <= alu_flags;
      end
      if (cv) begin
        BCondCheck <= cond_true;
        bcValid    <= 1'b1;
      end else if (!stall) begin
        BCondCheck <= 1'b0;
        bcValid    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
